m68k_bus_slave: RTL
===================

Name: m68k_bus_slave

Overview:
- Front-end between the asynchronous M68K CPU bus and the board controller's internal single-cycle request/ack target port.
- Synchronizes AS/strobes, latches address/data/byte-enables and issues one internal request per CPU bus cycle.
- Generates dtack_n on completion, or berr_n on target error or timeout.
- Sits directly upstream of the main controller/flash loader, which consumes its req/addr/wdata and returns ack/err/rdata.

Parameters:
- TIMEOUT_CYCLES, 255: clk cycles from req assertion without ack/err before a bus error is signalled (1..65535).
- SYNC_STAGES, 2: flip-flop depth of the strobe synchronizers (2 or 3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_fc  in  3  CPU function code
- cpu_addr  in  23  CPU address bus A23..A1
- cpu_data_in  in  16  CPU data bus, input side
- cpu_data_out  out  16  read data driven to CPU
- cpu_data_oe  out  1  enable for the top-level data bus tristate
- as_n  in  1  address strobe, async
- wrh_n / wrl_n  in  1 each  upper/lower byte write strobes, async
- rdh_n / rdl_n  in  1 each  upper/lower byte read strobes, async
- dtack_n  out  1  data acknowledge to CPU
- berr_n  out  1  bus error to CPU
- req  out  1  internal request, level, held until ack/err/timeout
- req_we  out  1  1 = write
- req_be  out  2  byte enables {upper, lower}
- req_addr  out  23  latched word address
- req_wdata  out  16  latched write data
- ack  in  1  target completion, one-cycle pulse
- err  in  1  target error, one-cycle pulse
- rdata  in  16  read data, valid with ack

Behaviour:
- Reset: dtack_n=1, berr_n=1, req=0, req_we=0, req_be=0, req_addr=0, req_wdata=0, cpu_data_out=0, cpu_data_oe=0, timeout counter=0, state=IDLE, synchronizer flops=1 (inactive).
- All outputs are registered.
- The as_n and four strobes pass through a SYNC_STAGES flop chain. The _s suffix denotes a synchronized signal.
- Start condition: as_s=0 and any strobe_s=0.
- Write cycle: any wr*_s=0; req_be={~wrh_s,~wrl_s}.
- Read cycle: otherwise; req_be={~rdh_s,~rdl_s}.
- If both read and write strobes are low, the cycle is treated as a write.

States:
- IDLE
  - Start with cpu_fc!=3'b111: latch cpu_addr, cpu_data_in, we and be; set req=1, counter=0; go REQ.
  - Start with cpu_fc==3'b111 (IACK): go IGNORE. No req, no dtack.
- REQ
  - Counter increments each cycle.
  - ack: req=0. On a read, capture rdata into cpu_data_out and set cpu_data_oe=1. dtack_n=0. Go TERM.
  - err (without ack): req=0, berr_n=0; go TERM.
  - ack and err in the same cycle: ack wins.
  - Counter==TIMEOUT_CYCLES-1 with no ack/err: req=0, berr_n=0; go TERM.
  - ack in the same cycle as timeout expiry: ack wins.
  - as_s=1 (CPU abort): req=0; go IDLE; no dtack/berr.
- TERM: hold dtack_n/berr_n/cpu_data_oe until as_s=1, then release all three to inactive in the same cycle and go IDLE.
- IGNORE: wait for as_s=1, then go IDLE.

Latency and rules:
- With SYNC_STAGES=2, req rises 3 clk after as_n/strobe fall. dtack_n falls 1 clk after ack.
- Exactly one req per AS assertion. A new cycle cannot start until as_s has been seen high.
- ack/err arriving while not in REQ are ignored.
- rst mid-cycle returns to the reset values at the next edge. The CPU times out externally.

Decomposition:
- Package m68k_bus_pkg holds:
  - state enum (IDLE, REQ, TERM, IGNORE)
  - FC_IACK=3'b111
  - BE_UPPER/BE_LOWER bit indices
  - default TIMEOUT_CYCLES
- One sub-module, m68k_sync: parameterized-depth synchronizer with a reset value input, instantiated for each of the 5 strobes.

Test Plan:
- Word read: as_n=0, rdh_n=rdl_n=0, addr=0x000400, fc=3'b101; target acks after 4 cycles with rdata=0xBEEF -> req at +3 clk, req_we=0, req_be=2'b11, req_addr=0x000400; dtack_n=0 one clk after ack; cpu_data_out=0xBEEF; oe and dtack released once as_n=1 has been synchronized.
- Byte write lower: wrl_n=0 only, data=0x00A5, addr=0x7FFFFF -> req_we=1, req_be=2'b01, req_wdata=0x00A5, req_addr=0x7FFFFF; cpu_data_oe stays 0.
- Timeout: TIMEOUT_CYCLES=8, target never acks -> req drops and berr_n=0 exactly 8 clk after req rose; dtack_n stays 1.
- Simultaneous ack+err, and ack on the timeout-expiry cycle -> dtack_n=0, berr_n stays 1 in both cases.
- IACK cycle with fc=3'b111 -> req never asserted, dtack_n/berr_n stay 1; the next normal cycle is serviced.
- Abort and reset: as_n returns high while in REQ -> req=0 next clk, no dtack. rst pulsed during TERM -> all outputs at reset values next clk, then a fresh cycle completes normally.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the M68K bus slave front-end.
//   state_e                 : bus-cycle sequencer states
//   FC_IACK                 : CPU function code of an interrupt-acknowledge cycle
//   BE_UPPER / BE_LOWER     : bit positions inside the 2-bit byte-enable vector
//   DEFAULT_TIMEOUT_CYCLES  : default target response budget in clk cycles
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StTerm,
    StIgnore
  } state_e;

  localparam logic [2:0] FC_IACK = 3'b111;

  localparam int unsigned BE_UPPER = 1;
  localparam int unsigned BE_LOWER = 0;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/m68k_sync.sv
// Single-bit flop-chain synchronizer for an asynchronous strobe.
//   clk     : destination clock
//   rst     : synchronous reset, active-high; loads every stage with rst_val
//   rst_val : value held by all stages while in reset (inactive strobe level)
//   d       : asynchronous input
//   q       : synchronized output (last stage)
module m68k_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{rst_val}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_slave.sv
// M68K asynchronous bus to internal request/ack target bridge.
// One internal request is issued per address-strobe assertion; the CPU cycle is
// terminated with dtack_n on ack, or berr_n on target error / response timeout.
//   clk, rst             : system clock, synchronous active-high reset
//   cpu_fc, cpu_addr     : CPU function code and word address (A23..A1)
//   cpu_data_in          : CPU write data
//   cpu_data_out/_oe     : read data and tristate enable toward the CPU bus
//   as_n, wr*_n, rd*_n   : asynchronous address strobe and byte read/write strobes
//   dtack_n, berr_n      : cycle termination back to the CPU
//   req, req_we, req_be  : internal request (level), direction, byte enables
//   req_addr, req_wdata  : latched address and write data
//   ack, err, rdata      : target completion pulse, error pulse, read data
module m68k_bus_slave
  import m68k_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cpu_fc,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_data_oe,
  input  logic        as_n,
  input  logic        wrh_n,
  input  logic        wrl_n,
  input  logic        rdh_n,
  input  logic        rdl_n,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        req,
  output logic        req_we,
  output logic [1:0]  req_be,
  output logic [22:0] req_addr,
  output logic [15:0] req_wdata,
  input  logic        ack,
  input  logic        err,
  input  logic [15:0] rdata
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Synchronized strobes, order {as, wrh, wrl, rdh, rdl}.
  logic [4:0] strobe_n;
  logic [4:0] strobe_s;
  logic       as_s, wrh_s, wrl_s, rdh_s, rdl_s;

  assign strobe_n = {as_n, wrh_n, wrl_n, rdh_n, rdl_n};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    m68k_sync #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .rst_val (1'b1),
      .d       (strobe_n[i]),
      .q       (strobe_s[i])
    );
  end

  assign {as_s, wrh_s, wrl_s, rdh_s, rdl_s} = strobe_s;

  // Start decode. Any write strobe makes it a write, even with read strobes low.
  logic       wr_any, rd_any, start;
  logic [1:0] start_be;

  assign wr_any = ~wrh_s | ~wrl_s;
  assign rd_any = ~rdh_s | ~rdl_s;
  assign start  = ~as_s & (wr_any | rd_any);

  always_comb begin
    start_be = '0;
    if (wr_any) begin
      start_be[BE_UPPER] = ~wrh_s;
      start_be[BE_LOWER] = ~wrl_s;
    end else begin
      start_be[BE_UPPER] = ~rdh_s;
      start_be[BE_LOWER] = ~rdl_s;
    end
  end

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dtack_n_q, dtack_n_d;
  logic        berr_n_q, berr_n_d;
  logic        req_q, req_d;
  logic        req_we_q, req_we_d;
  logic [1:0]  req_be_q, req_be_d;
  logic [22:0] req_addr_q, req_addr_d;
  logic [15:0] req_wdata_q, req_wdata_d;
  logic [15:0] data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dtack_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
      req_q       <= 1'b0;
      req_we_q    <= 1'b0;
      req_be_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dtack_n_q   <= dtack_n_d;
      berr_n_q    <= berr_n_d;
      req_q       <= req_d;
      req_we_q    <= req_we_d;
      req_be_q    <= req_be_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dtack_n_d   = dtack_n_q;
    berr_n_d    = berr_n_q;
    req_d       = req_q;
    req_we_d    = req_we_q;
    req_be_d    = req_be_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (cpu_fc == FC_IACK) begin
            state_d = StIgnore;
          end else begin
            req_addr_d  = cpu_addr;
            req_wdata_d = cpu_data_in;
            req_we_d    = wr_any;
            req_be_d    = start_be;
            req_d       = 1'b1;
            cnt_d       = '0;
            state_d     = StReq;
          end
        end
      end

      StReq: begin
        cnt_d = cnt_q + 16'd1;
        // A CPU that already dropped AS is no longer waiting; never terminate
        // a cycle it has abandoned.
        if (as_s) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (ack) begin
          req_d     = 1'b0;
          dtack_n_d = 1'b0;
          if (!req_we_q) begin
            data_out_d = rdata;
            data_oe_d  = 1'b1;
          end
          state_d = StTerm;
        end else if (err || (cnt_q == TIMEOUT_LAST)) begin
          req_d    = 1'b0;
          berr_n_d = 1'b0;
          state_d  = StTerm;
        end
      end

      StTerm: begin
        if (as_s) begin
          dtack_n_d = 1'b1;
          berr_n_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = StIdle;
        end
      end

      StIgnore: begin
        if (as_s) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign dtack_n      = dtack_n_q;
  assign berr_n       = berr_n_q;
  assign req          = req_q;
  assign req_we       = req_we_q;
  assign req_be       = req_be_q;
  assign req_addr     = req_addr_q;
  assign req_wdata    = req_wdata_q;
  assign cpu_data_out = data_out_q;
  assign cpu_data_oe  = data_oe_q;

endmodule
